// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - 3-wire serial byte receiver with synchronized inputs and ready/ack output
// Optional frame_err output enabled by defining SPI_RX_FRAME_ERR_EN.

module spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dev_stb,
    input  logic       dev_clk,
    input  logic       dev_dio,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       rx_ack,
    output logic       rx_ovr,
    output logic       busy
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] stb_sr, clk_sr, dio_sr;
    logic                   stb_s, clk_s, dio_s;
    logic                   clk_prev;
    logic                   clk_rise;
    logic [7:0]             shift;
    logic [2:0]             cnt;
    logic                   done;

    // Identical chains keep the relative ordering of the three lines intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_sr   <= '1;
            clk_sr   <= '1;
            dio_sr   <= '1;
            clk_prev <= 1'b1;
        end else begin
            stb_sr   <= {stb_sr[SYNC_STAGES-2:0], dev_stb};
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], dev_clk};
            dio_sr   <= {dio_sr[SYNC_STAGES-2:0], dev_dio};
            clk_prev <= clk_s;
        end
    end

    assign stb_s    = stb_sr[SYNC_STAGES-1];
    assign clk_s    = clk_sr[SYNC_STAGES-1];
    assign dio_s    = dio_sr[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!stb_s) state_nxt = SHIFT;
            SHIFT:   if (stb_s)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Strobe release wins over a coincident clock edge: the frame is over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= 8'h00;
            cnt   <= 3'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == SHIFT && !stb_s) begin
                if (clk_rise) begin
                    shift <= {dio_s, shift[7:1]};
                    cnt   <= cnt + 3'd1;
                    done  <= (cnt == 3'd7);
                end
            end else begin
                cnt <= 3'd0;
            end
        end
    end

    // shift stays stable for several cycles after completion, so it is read directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            rx_ovr  <= 1'b0;
        end else if (done) begin
            if (!rx_rdy) begin
                rx_data <= shift;
                rx_rdy  <= 1'b1;
            end else if (rx_ack) begin
                rx_data <= shift;
                rx_ovr  <= 1'b0;
            end else begin
                rx_ovr  <= 1'b1;
            end
        end else if (rx_ack && rx_rdy) begin
            rx_rdy <= 1'b0;
            rx_ovr <= 1'b0;
        end
    end

`ifdef SPI_RX_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == SHIFT) && stb_s && (cnt != 3'd0);
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - self-checking bench for spi_rx using a pin-level event model

module tb_spi_rx;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_stb = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dio = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ovr;
    logic       busy;
`ifdef SPI_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    spi_rx #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .dev_stb  (dev_stb),
        .dev_clk  (dev_clk),
        .dev_dio  (dev_dio),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .rx_ack   (rx_ack),
        .rx_ovr   (rx_ovr),
        .busy     (busy)
`ifdef SPI_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] b;
    } cmpl_t;

    typedef struct {
        int   due;
        logic busy_v;
        logic ferr;
    } bev_t;

    cmpl_t cq[$];
    bev_t  bq[$];

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] e_data = 8'h00;
    logic       e_rdy = 1'b0;
    logic       e_ovr = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_ferr = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_bits = 8'h00;
    logic       p_stb = 1'b1;
    logic       p_clk = 1'b1;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        e_data = 8'h00;
        e_rdy  = 1'b0;
        e_ovr  = 1'b0;
        e_busy = 1'b0;
        e_ferr = 1'b0;
        m_cnt  = 0;
        cq.delete();
        bq.delete();
    endtask

    // Model: scheduled output effects of pin events, applied at the edge they are due.
    always @(posedge clk) begin
        cyc++;
        e_ferr = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (bq.size() > 0 && bq[0].due == cyc) begin
                e_busy = bq[0].busy_v;
                e_ferr = bq[0].ferr;
                void'(bq.pop_front());
            end
            if (cq.size() > 0 && cq[0].due == cyc) begin
                if (!e_rdy) begin
                    e_data = cq[0].b;
                    e_rdy  = 1'b1;
                end else if (rx_ack) begin
                    e_data = cq[0].b;
                    e_ovr  = 1'b0;
                end else begin
                    e_ovr = 1'b1;
                end
                void'(cq.pop_front());
            end else if (rx_ack && e_rdy) begin
                e_rdy = 1'b0;
                e_ovr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("rx_rdy", 8'(rx_rdy), 8'(e_rdy));
        check("rx_data", rx_data, e_data);
        check("rx_ovr", 8'(rx_ovr), 8'(e_ovr));
        check("busy", 8'(busy), 8'(e_busy));
`ifdef SPI_RX_FRAME_ERR_EN
        check("frame_err", 8'(frame_err), 8'(e_ferr));
`endif
    end

    // Drive all three pins, record their consequences in the model, hold two clk cycles.
    task automatic step(input logic s, input logic c, input logic d);
        bev_t  be;
        cmpl_t ce;
        @(posedge clk);
        #1;
        if (p_stb && !s) begin
            be.due = cyc + S + 1; be.busy_v = 1'b1; be.ferr = 1'b0;
            bq.push_back(be);
        end
        if (!p_stb && s) begin
            be.due = cyc + S + 1; be.busy_v = 1'b0; be.ferr = (m_cnt != 0);
            bq.push_back(be);
            m_cnt = 0;
        end
        if (!p_clk && c && !s && !p_stb) begin
            m_bits[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 8) begin
                ce.due = cyc + S + 2; ce.b = m_bits;
                cq.push_back(ce);
                m_cnt = 0;
            end
        end
        dev_stb = s;
        dev_clk = c;
        dev_dio = d;
        p_stb   = s;
        p_clk   = c;
        @(posedge clk);
    endtask

    task automatic frame_begin();
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame_end();
        step(1'b1, 1'b1, 1'b1);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            step(1'b0, 1'b0, b[i]);
            step(1'b0, 1'b1, b[i]);
            if (ack_last && i == nbits - 1) begin
                repeat (S) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_rdy", 8'(rx_rdy), 8'h00);
        check("reset rx_ovr", 8'(rx_ovr), 8'h00);
        check("reset busy", 8'(busy), 8'h00);

        frame_begin(); send_bits(8'hA5, 8, 1'b0); frame_end(); settle();
        check("a5 data", rx_data, 8'hA5);
        check("a5 rdy", 8'(rx_rdy), 8'h01);
        check("a5 ovr", 8'(rx_ovr), 8'h00);
        check("a5 busy", 8'(busy), 8'h00);
        ack_pulse(); settle();

        frame_begin(); send_bits(8'h3C, 8, 1'b0); settle();
        ack_pulse(); send_bits(8'hC3, 8, 1'b0); frame_end(); settle();
        check("c3 data", rx_data, 8'hC3);
        check("c3 ovr", 8'(rx_ovr), 8'h00);
        ack_pulse(); settle();

        frame_begin(); send_bits(8'h01, 8, 1'b0); send_bits(8'h80, 8, 1'b0); frame_end(); settle();
        check("ovr data", rx_data, 8'h01);
        check("ovr flag", 8'(rx_ovr), 8'h01);
        check("ovr rdy", 8'(rx_rdy), 8'h01);
        ack_pulse();
        @(negedge clk);
        check("ack clears rdy", 8'(rx_rdy), 8'h00);
        check("ack clears ovr", 8'(rx_ovr), 8'h00);

        frame_begin(); send_bits(8'hFF, 5, 1'b0); frame_end(); settle();
        check("trunc no rdy", 8'(rx_rdy), 8'h00);
        frame_begin(); send_bits(8'h5A, 8, 1'b0); frame_end(); settle();
        check("5a data", rx_data, 8'h5A);
        check("5a rdy", 8'(rx_rdy), 8'h01);

        frame_begin(); send_bits(8'h6B, 3, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("async rst rdy", 8'(rx_rdy), 8'h00);
        check("async rst data", rx_data, 8'h00);
        check("async rst busy", 8'(busy), 8'h00);
        dev_stb = 1'b1; dev_clk = 1'b1; dev_dio = 1'b1;
        p_stb = 1'b1; p_clk = 1'b1; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        frame_begin(); send_bits(8'h96, 8, 1'b0); frame_end(); settle();
        check("96 data", rx_data, 8'h96);
        ack_pulse(); settle();

        frame_begin(); send_bits(8'h11, 8, 1'b0); frame_end(); settle();
        check("11 data", rx_data, 8'h11);
        frame_begin(); send_bits(8'h77, 8, 1'b1); frame_end(); settle();
        check("77 data", rx_data, 8'h77);
        check("77 rdy", 8'(rx_rdy), 8'h01);
        check("77 ovr", 8'(rx_ovr), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
